// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch address generator plus {pc,instr} FIFO feeding decode; optional IFQ_BYPASS_EN empty-FIFO bypass.
// Latency: request in t -> id_valid in t+2 (t+1 with IFQ_BYPASS_EN); redirect target visible at r+2 (r+1).
// Backpressure: id_ready low holds the head; fetch stops while FIFO count plus in-flight request reaches DEPTH.
module instr_fetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [PC_W-1:0]  id_pc,
    output logic [INS_W-1:0] id_instr,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fpc_q, fpc_d;
    logic             infl_q, infl_d;
    logic [PC_W-1:0]  infl_pc_q, infl_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [INS_W-1:0] ins_mem_q [DEPTH];

    logic [CNT_W:0] occ;
    logic           empty;
    logic           full;
    logic           resp_vld;
    logic           byp_vld;
    logic           byp_take;
    logic           push;
    logic           pop;

    // The in-flight request already owns a FIFO slot, so it counts against credit.
    assign occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, infl_q};
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    // A redirect kills whatever response returns in the same cycle.
    assign resp_vld = infl_q & ~redirect;

`ifdef IFQ_BYPASS_EN
    assign byp_vld  = empty & resp_vld;
`else
    assign byp_vld  = 1'b0;
`endif
    assign byp_take = byp_vld & id_ready;
    assign pop      = ~empty & id_ready & ~redirect;
    assign push     = resp_vld & ~byp_take;
    assign count    = count_q;

    // Fetch request/address; forced idle while reset is asserted so redirect cannot leak through.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        if (reset) begin
            imem_req  = redirect | (occ < DEPTH_OCC);
            imem_addr = redirect ? redirect_pc : fpc_q;
        end
    end

    // Head presentation: FIFO head first, else the bypassed response, else zeros.
    always_comb begin
        id_valid = 1'b0;
        id_pc    = '0;
        id_instr = '0;
        if (!empty) begin
            id_valid = 1'b1;
            id_pc    = pc_mem_q[rd_ptr_q];
            id_instr = ins_mem_q[rd_ptr_q];
        end else if (byp_vld) begin
            id_valid = 1'b1;
            id_pc    = infl_pc_q;
            id_instr = imem_rdata;
        end
    end

    // Next-state for fetch PC, in-flight tracking and FIFO pointers/occupancy.
    always_comb begin
        fpc_d     = fpc_q;
        infl_d    = imem_req;
        infl_pc_d = infl_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (imem_req) begin
            fpc_d     = imem_addr + PC_W'(4);
            infl_pc_d = imem_addr;
        end
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q     <= '0;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Entry storage; contents are only observable while count is non-zero, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= infl_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full))
        else $error("instr_fetch_queue: push into full FIFO");
`endif

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end for the 5-stage RISC-V pipeline. It generates fetch addresses into the synchronous-read instruction memory and buffers returned instructions together with their PCs in a small FIFO. It presents them to the IF/ID boundary through a valid/ready handshake. Branch and jump redirects from the execute-stage branch unit flush the queue and restart fetch at the target.

## Interface
- PC_W, 9, program-counter / instruction-memory address width
- INS_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  fetch address; memory returns data one cycle later
- imem_rdata  in  INS_W  instruction for the request issued the previous cycle
- redirect  in  1  flush and restart; driven by the branch unit's PC-select
- redirect_pc  in  PC_W  restart target
- id_ready  in  1  decode accepts the head entry; low during a load-use stall
- id_valid  out  1  head entry valid
- id_pc  out  PC_W  PC of head entry
- id_instr  out  INS_W  head instruction; 0 when id_valid=0
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- State:
  - fetch PC `fpc`
  - in-flight flag `infl` plus its PC `infl_pc`
  - FIFO of {pc, instr} with read/write pointers and occupancy.
- Issue rule: imem_req = redirect | (count + infl < DEPTH). The same-cycle pop does not add credit.
- imem_addr = redirect ? redirect_pc : fpc.
- On an issued request, fpc ← imem_addr + 4, modulo 2^PC_W. Example: 0x1FC + 4 → 0x000. `infl` ← 1 and `infl_pc` ← imem_addr.
- Response cycle (infl=1, no redirect): {infl_pc, imem_rdata} is pushed. infl clears unless a new request issued.
- Pop: id_valid & id_ready advances the read pointer.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.
- Push into a full FIFO cannot occur by construction. An assertion flags it.
- Redirect:
  - FIFO emptied (count ← 0).
  - Any response arriving this cycle is discarded.
  - A simultaneous pop is ignored.
  - A new request to redirect_pc issues the same cycle; infl ← 1.
- When empty, id_pc and id_instr are driven 0.
- Reset asserted: everything clears immediately, regardless of the clock.
  - fpc=0, infl=0, count=0, pointers=0.
  - Outputs: imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_instr=0.
- First request after reset deasserts is at address 0.

## Timing
- Fetch latency without bypass:
  - Request in cycle t; data captured at the end of t+1; id_valid in t+2.
- Steady state with id_ready=1: one instruction per cycle after the initial 2-cycle fill.
- Redirect in cycle r: target instruction appears at id_valid in r+2 (r+1 with bypass). The pipeline sees 1–2 empty cycles, so the datapath's flush NOP is reproduced naturally.
- id_ready low: the head is held stable.
  - Fetch stops once count + infl = DEPTH.
  - No entry is lost or duplicated.
- imem_addr and imem_req are combinational from state and redirect. The redirect path must fit one cycle.

## Configuration
- IFQ_BYPASS_EN defined: when the FIFO is empty and a valid response arrives, it is presented on id_valid/id_pc/id_instr in the same cycle. If id_ready is high it is consumed without being written; otherwise it is written normally. Fetch latency is 1 cycle.
- IFQ_BYPASS_EN undefined: all responses pass through the FIFO; latency is 2 cycles.
- Both builds have identical ordering and redirect semantics.

## Test plan
- Reset release, id_ready=1, imem[a]=0x00100093+a: id_valid first in cycle 2. id_pc sequence is 0x000, 0x004, 0x008… with matching data, one per cycle.
- id_ready=0 for 10 cycles from reset release:
  - count saturates at 4 and imem_req drops.
  - On release, outputs are PCs 0x000, 0x004, 0x008, 0x00C, 0x010 in order, no gaps or repeats.
- With 3 entries queued plus one in flight, pulse redirect with redirect_pc=0x040:
  - count=0 next cycle.
  - Next valid output is pc 0x040 in r+2, followed by 0x044.
  - No stale PC (0x00C etc.) is ever emitted.
- Redirect to 0x1F8, id_ready=1: outputs 0x1F8, 0x1FC, 0x000, 0x004 (wrap-around).
- Redirect and id_ready=1 in the same cycle with a head entry valid: the head is not counted as consumed and the next output is the target. Then assert reset between clock edges mid-stream: id_valid, id_pc, id_instr, imem_req all go 0 immediately.
- IFQ_BYPASS_EN: from reset release, first id_valid in cycle 1. Redirect latency is r+1. Repeat the stall scenario with identical ordering.
